// File: rtl/vlogic_issue_seq.sv
// Issue sequencer for the vector logic unit: accepts a command, streams operand beats to the ALU
// with an outstanding-beat limit, drains results, then signals done. Optional: VLOGIC_SEQ_MASK_EN.
module vlogic_issue_seq #(
  parameter int unsigned REQ_DATA_WIDTH  = 64,
  parameter int unsigned REQ_ADDR_WIDTH  = 32,
  parameter int unsigned OPSEL_WIDTH     = 3,
  parameter int unsigned LEN_WIDTH       = 8,
  parameter int unsigned MAX_OUTSTANDING = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      cmd_valid,
  output logic                      cmd_ready,
  input  logic [REQ_ADDR_WIDTH-1:0] cmd_addr,
  input  logic [LEN_WIDTH-1:0]      cmd_len,
  input  logic [OPSEL_WIDTH-1:0]    cmd_opsel,
  input  logic                      cmd_sca,
  input  logic                      cmd_w_reg,
  input  logic                      cmd_mask,
  input  logic                      opnd_valid,
  output logic                      opnd_ready,
  input  logic [REQ_DATA_WIDTH-1:0] opnd_vec0,
  input  logic [REQ_DATA_WIDTH-1:0] opnd_vec1,
  output logic                      alu_valid,
  output logic [REQ_ADDR_WIDTH-1:0] alu_addr,
  output logic [REQ_DATA_WIDTH-1:0] alu_vec0,
  output logic [REQ_DATA_WIDTH-1:0] alu_vec1,
  output logic [OPSEL_WIDTH-1:0]    alu_opsel,
  output logic                      alu_sca,
  output logic                      alu_w_reg,
  output logic                      alu_mask,
  input  logic                      res_valid,
  output logic                      busy,
  output logic                      done,
  output logic                      cmd_err
);

  localparam int unsigned CntW = 4;

`ifdef VLOGIC_SEQ_MASK_EN
  localparam bit MaskEn = 1'b1;
`else
  localparam bit MaskEn = 1'b0;
`endif

  typedef enum logic [1:0] {StIdle, StIssue, StDrain} state_e;

  state_e                    state_q, state_d;
  logic [REQ_ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [LEN_WIDTH-1:0]      len_q, len_d;
  logic [LEN_WIDTH-1:0]      idx_q, idx_d;
  logic [OPSEL_WIDTH-1:0]    opsel_q, opsel_d;
  logic                      sca_q, sca_d, w_reg_q, w_reg_d, mask_q, mask_d;
  logic [CntW-1:0]           cnt_q, cnt_d;
  logic                      done_q, done_d, err_q, err_d;

  logic                      alu_valid_q, alu_valid_d;
  logic [REQ_ADDR_WIDTH-1:0] alu_addr_q, alu_addr_d;
  logic [REQ_DATA_WIDTH-1:0] alu_vec0_q, alu_vec0_d, alu_vec1_q, alu_vec1_d;
  logic [OPSEL_WIDTH-1:0]    alu_opsel_q, alu_opsel_d;
  logic                      alu_sca_q, alu_sca_d, alu_w_reg_q, alu_w_reg_d;
  logic                      alu_mask_q, alu_mask_d;

  logic cmd_fire, opnd_fire, opsel_legal, cnt_inc, cnt_dec;

  assign cmd_ready   = (state_q == StIdle) & ~rst;
  assign opnd_ready  = (state_q == StIssue) & (cnt_q < CntW'(MAX_OUTSTANDING));
  assign cmd_fire    = cmd_valid & cmd_ready;
  assign opnd_fire   = opnd_valid & opnd_ready;
  // Without the mask feature only 001, 010 and 011 are implemented.
  assign opsel_legal = MaskEn | ((cmd_opsel != '0) & ~cmd_opsel[OPSEL_WIDTH-1]);

  // Stray results with nothing outstanding are dropped instead of underflowing.
  assign cnt_inc = opnd_fire;
  assign cnt_dec = res_valid & (cnt_q != '0);

  always_comb begin
    cnt_d = cnt_q;
    if (cnt_inc && !cnt_dec) begin
      cnt_d = cnt_q + CntW'(1);
    end else if (cnt_dec && !cnt_inc) begin
      cnt_d = cnt_q - CntW'(1);
    end
  end

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    len_d       = len_q;
    idx_d       = idx_q;
    opsel_d     = opsel_q;
    sca_d       = sca_q;
    w_reg_d     = w_reg_q;
    mask_d      = mask_q;
    done_d      = 1'b0;
    err_d       = 1'b0;
    alu_valid_d = 1'b0;
    alu_addr_d  = '0;
    alu_vec0_d  = '0;
    alu_vec1_d  = '0;
    alu_opsel_d = '0;
    alu_sca_d   = 1'b0;
    alu_w_reg_d = 1'b0;
    alu_mask_d  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (cmd_fire) begin
          if (!opsel_legal) begin
            err_d = 1'b1;
          end else begin
            addr_d  = cmd_addr;
            len_d   = cmd_len;
            idx_d   = '0;
            opsel_d = cmd_opsel;
            sca_d   = cmd_sca;
            w_reg_d = cmd_w_reg;
            mask_d  = cmd_mask & MaskEn;
            if (cmd_len == '0) begin
              done_d = 1'b1;
            end else begin
              state_d = StIssue;
            end
          end
        end
      end
      StIssue: begin
        if (opnd_fire) begin
          alu_valid_d = 1'b1;
          alu_addr_d  = addr_q + REQ_ADDR_WIDTH'(idx_q);
          alu_vec0_d  = opnd_vec0;
          alu_vec1_d  = opnd_vec1;
          alu_opsel_d = opsel_q;
          alu_sca_d   = sca_q;
          alu_w_reg_d = w_reg_q;
          alu_mask_d  = mask_q;
          idx_d       = idx_q + LEN_WIDTH'(1);
          if (idx_q == len_q - LEN_WIDTH'(1)) begin
            state_d = StDrain;
          end
        end
      end
      StDrain: begin
        if (cnt_d == '0) begin
          done_d  = 1'b1;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      addr_q      <= '0;
      len_q       <= '0;
      idx_q       <= '0;
      opsel_q     <= '0;
      sca_q       <= 1'b0;
      w_reg_q     <= 1'b0;
      mask_q      <= 1'b0;
      cnt_q       <= '0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      alu_valid_q <= 1'b0;
      alu_addr_q  <= '0;
      alu_vec0_q  <= '0;
      alu_vec1_q  <= '0;
      alu_opsel_q <= '0;
      alu_sca_q   <= 1'b0;
      alu_w_reg_q <= 1'b0;
      alu_mask_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      len_q       <= len_d;
      idx_q       <= idx_d;
      opsel_q     <= opsel_d;
      sca_q       <= sca_d;
      w_reg_q     <= w_reg_d;
      mask_q      <= mask_d;
      cnt_q       <= cnt_d;
      done_q      <= done_d;
      err_q       <= err_d;
      alu_valid_q <= alu_valid_d;
      alu_addr_q  <= alu_addr_d;
      alu_vec0_q  <= alu_vec0_d;
      alu_vec1_q  <= alu_vec1_d;
      alu_opsel_q <= alu_opsel_d;
      alu_sca_q   <= alu_sca_d;
      alu_w_reg_q <= alu_w_reg_d;
      alu_mask_q  <= alu_mask_d;
    end
  end

  assign alu_valid = alu_valid_q;
  assign alu_addr  = alu_addr_q;
  assign alu_vec0  = alu_vec0_q;
  assign alu_vec1  = alu_vec1_q;
  assign alu_opsel = alu_opsel_q;
  assign alu_sca   = alu_sca_q;
  assign alu_w_reg = alu_w_reg_q;
  assign alu_mask  = alu_mask_q;
  assign busy      = (state_q != StIdle);
  assign done      = done_q;
  assign cmd_err   = err_q;

endmodule
